uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver completes, signalled by `data_out`/`rx_ready`, into a synchronous circular FIFO. The host side drains bytes at its own pace through a registered read port. The block also reports fill level and keeps a sticky overflow flag, so bytes arriving faster than the host reads are counted as lost and never silently overwrite stored data.

## Interface
- `DATA_W`, default 8: byte width; must match receiver `data_out`.
- `DEPTH`, default 16: number of entries; power of 2, minimum 2.
- `ADDR_W`, default $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `rx_data` in DATA_W: received byte, connected to receiver `data_out`; sampled on the push cycle.
- `rx_ready` in 1: receiver byte-complete indication; may be a pulse or a held level.
- `rd_en` in 1: host pop request.
- `dout` out DATA_W: popped byte; holds its value between pops.
- `dout_valid` out 1: one-cycle strobe, `dout` updated this cycle.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `count` out ADDR_W+1: current fill level, 0..DEPTH.
- `overflow` out 1: sticky lost-byte flag.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Push detection: register `rx_ready_q`. Push request = `rx_ready & ~rx_ready_q`, the rising edge. A level held for many cycles produces exactly one push.
- `rx_ready_q` resets to 1. A `rx_ready` level already high when reset releases must not push.
- Pop request = `rd_en & ~empty`. `rd_en` while empty is ignored: no pointer move, no `dout_valid`.
- Push accepted when `~full`, or when `full` and a pop is accepted in the same cycle.
  - Accepted push writes `rx_data` at `wr_ptr` and increments `wr_ptr` modulo DEPTH.
- Push while `full` with no pop: byte dropped, `overflow` set to 1; pointers and count unchanged.
- Pop: `dout <= mem[rd_ptr]`, `rd_ptr` increments modulo DEPTH, `dout_valid` = 1 next cycle.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop or neither.
- Simultaneous push+pop when empty: pop is not accepted (empty), push accepted, count becomes 1.
- Simultaneous push+pop when full: both accepted. The popped byte is the oldest entry, the new byte takes the freed slot, count stays DEPTH.
- `overflow` is cleared by `ovf_clr`. If an overflow event and `ovf_clr` occur in the same cycle, set wins and `overflow` stays 1.
- Pointers are ADDR_W bits and wrap naturally. `full`/`empty` derive from `count`, never from pointer equality.
- Reset mid-operation discards all stored bytes; memory contents need not be cleared.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `overflow` = 0.
  - `wr_ptr` = `rd_ptr` = 0, `rx_ready_q` = 1.
- Push latency: `rx_ready` rises in cycle N; `count`, `empty` and `full` reflect the push at cycle N+1.
- Read latency: `rd_en` high in cycle N with `empty` = 0 gives `dout` and `dout_valid` at N+1.
- Back-to-back pops on consecutive cycles are supported, one byte per cycle.
- Status outputs are registered; no combinational path from inputs to outputs.
- Throughput bound: one push per cycle maximum. The receiver produces one byte per roughly 10 bit periods, far below that bound.

## Test plan
- Reset release with `rx_ready` held high:
  - Required: count stays 0, `empty` = 1.
  - Then drop `rx_ready`, pulse it with `rx_data` = 0x75: count = 1.
- Push 0xAE, 0x75, 0x3C as separate `rx_ready` edges, then `rd_en` for 3 cycles:
  - Required: `dout` = 0xAE, 0x75, 0x3C on consecutive cycles, each with `dout_valid`.
  - Final state: `empty` = 1, count = 0.
- Hold `rx_ready` high for 50 cycles with `rx_data` = 0x55: exactly one entry, count = 1.
- Fill to 16 with 0x00..0x0F, then push 0xFF:
  - Required: `full` = 1, `overflow` = 1, count = 16, 0xFF dropped.
  - Drain: reads 0x00..0x0F in order.
  - Pulse `ovf_clr`: `overflow` = 0.
- At full, push 0xA5 and `rd_en` in the same cycle:
  - Required: `dout` = oldest byte, count stays 16, `overflow` stays 0.
  - 0xA5 is read out last after wrap-around.
- `rd_en` while empty: no `dout_valid`, `dout` unchanged.
- Mid-fill reset: load 5 bytes, assert `rst_n` = 0 for 1 cycle. Required: count = 0, `empty` = 1, `overflow` = 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer placed right after the UART receiver. Each byte
//   the receiver completes is captured into a circular FIFO on the rising
//   edge of rx_ready. The host drains bytes through a registered read port.
//   The block reports the fill level and keeps a sticky overflow flag for
//   bytes that arrive while the buffer is full; stored data is never
//   overwritten.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   rx_data    in   received byte (receiver data_out), sampled on push
//   rx_ready   in   receiver byte-complete (pulse or held level)
//   rd_en      in   host pop request
//   dout       out  popped byte, holds between pops
//   dout_valid out  one-cycle strobe: dout updated this cycle
//   empty      out  count == 0
//   full       out  count == DEPTH
//   count      out  fill level 0..DEPTH
//   overflow   out  sticky lost-byte flag
//   ovf_clr    in   clears overflow (an overflow in the same cycle wins)
//
// Handshake: a push is offered on each 0->1 transition of rx_ready and is
// accepted when the FIFO has room after this cycle's pop; a pop is accepted
// whenever rd_en is high and the FIFO is not empty, and its byte appears on
// dout with dout_valid one cycle later. There is no back-pressure to the
// receiver, so a push that cannot be accepted is dropped and flagged.

module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rx_ready_q;

  logic              push_req;
  logic              pop;
  logic              push_acc;
  logic              ovf_event;
  logic [ADDR_W:0]   count_nxt;

  // rx_ready_q resets high so a level already asserted when reset releases
  // is not mistaken for a fresh byte.
  assign push_req  = rx_ready & ~rx_ready_q;
  assign pop       = rd_en & ~empty;
  // At full, a same-cycle pop frees the slot the new byte lands in.
  assign push_acc  = push_req & (~full | pop);
  assign ovf_event = push_req & full & ~pop;

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; a reset only discards it by zeroing pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ready_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      dout_valid <= pop;
      if (pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // empty/full are registered from the next count, never from pointers.
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_C);
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
